// File: rtl/plc_list_loader_if.sv
// Host command channel and PLC list port of the list loader, grouped with
// modports for the loader (slave) and its environment (master).
interface plc_list_loader_if #(
    parameter int unsigned LIST_DEPTH = 16
);
    localparam int unsigned LC_W = $clog2(LIST_DEPTH + 1);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_addr;
    logic [3:0]      cmd_way;
    logic [63:0]     cmd_data;
    logic            clear_list;
    logic            add_to_list;
    logic [7:0]      addr_out;
    logic [3:0]      way_out;
    logic            write_enable;
    logic [63:0]     data;
    logic            plc_error_found;
    logic            list_full;
    logic [LC_W-1:0] loaded_count;
    logic            error_sticky;
    logic [7:0]      error_count;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_way, cmd_data, clear_list, plc_error_found,
        output cmd_ready, add_to_list, addr_out, way_out, write_enable, data,
               list_full, loaded_count, error_sticky, error_count
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_way, cmd_data, clear_list, plc_error_found,
        input  cmd_ready, add_to_list, addr_out, way_out, write_enable, data,
               list_full, loaded_count, error_sticky, error_count
    );
endinterface

// File: rtl/plc_list_loader.sv
// Buffers host list entries in a small FIFO and replays each one to the PLC
// as an announce strobe followed by a write strobe, with error bookkeeping.
module plc_list_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LIST_DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    plc_list_loader_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LC_W  = $clog2(LIST_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ANNOUNCE = 2'd1,
        WRITE    = 2'd2,
        GAP      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        fifo_addr_q [FIFO_DEPTH];
    logic [3:0]        fifo_way_q  [FIFO_DEPTH];
    logic [63:0]       fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_c, push_c, pop_c;
    logic              add_q, add_d, we_q, we_d;
    logic [7:0]        addr_q;
    logic [3:0]        way_q;
    logic [63:0]       data_q;
    logic [LC_W-1:0]   loaded_q, loaded_d;
    logic              full_q, full_d;
    logic              sticky_q;
    logic [7:0]        errc_q;

    // Ready looks only at stored occupancy; a same-cycle pop frees nothing.
    assign ready_c = ~rst & (count_q < CNT_W'(FIFO_DEPTH));
    assign push_c  = bus.cmd_valid & ready_c;

    // Sequencer next state, strobe and counter next values.
    always_comb begin
        state_d  = state_q;
        pop_c    = 1'b0;
        loaded_d = loaded_q;
        case (state_q)
            IDLE, GAP: begin
                if ((count_q != '0) && !full_q) begin
                    pop_c   = 1'b1;
                    state_d = ANNOUNCE;
                end else begin
                    state_d = IDLE;
                end
            end
            ANNOUNCE: state_d = WRITE;
            WRITE:    state_d = GAP;
            default:  state_d = IDLE;
        endcase
        add_d = (state_d == ANNOUNCE);
        we_d  = (state_d == WRITE);
        if (bus.clear_list) begin
            loaded_d = '0;
        end else if ((state_q == WRITE) && (loaded_q < LC_W'(LIST_DEPTH))) begin
            loaded_d = loaded_q + LC_W'(1);
        end
        full_d  = (loaded_d == LC_W'(LIST_DEPTH));
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Entry storage carries no reset; only written slots are ever read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_addr_q[wr_ptr_q] <= bus.cmd_addr;
            fifo_way_q[wr_ptr_q]  <= bus.cmd_way;
            fifo_data_q[wr_ptr_q] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            add_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            way_q    <= '0;
            data_q   <= '0;
            loaded_q <= '0;
            full_q   <= 1'b0;
            sticky_q <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            add_q    <= add_d;
            we_q     <= we_d;
            loaded_q <= loaded_d;
            full_q   <= full_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                addr_q   <= fifo_addr_q[rd_ptr_q];
                way_q    <= fifo_way_q[rd_ptr_q];
                data_q   <= fifo_data_q[rd_ptr_q];
            end
            if (bus.plc_error_found) begin
                sticky_q <= 1'b1;
                if (errc_q != 8'hFF) begin
                    errc_q <= errc_q + 8'd1;
                end
            end
        end
    end

    assign bus.cmd_ready    = ready_c;
    assign bus.add_to_list  = add_q;
    assign bus.write_enable = we_q;
    assign bus.addr_out     = addr_q;
    assign bus.way_out      = way_q;
    assign bus.data         = data_q;
    assign bus.loaded_count = loaded_q;
    assign bus.list_full    = full_q;
    assign bus.error_sticky = sticky_q;
    assign bus.error_count  = errc_q;
endmodule

// File: tb/tb_plc_list_loader.sv
// Directed bench for plc_list_loader: a queue/timestamp model of the loader
// is checked every cycle, alongside literal expectations per scenario.
module tb_plc_list_loader;
    localparam int unsigned FD = 4;
    localparam int unsigned LD = 2;

    typedef struct packed {
        logic [7:0]  a;
        logic [3:0]  w;
        logic [63:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    plc_list_loader_if #(.LIST_DEPTH(LD)) bus ();

    plc_list_loader #(.FIFO_DEPTH(FD), .LIST_DEPTH(LD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state, valid after each rising edge.
    ent_t mq[$];
    ent_t m_hold, m_new;
    bit   m_add, m_we, m_full, m_sticky, m_valid, m_acc, m_pop;
    int   m_lc, m_lcn, m_errc, e_cnt, last_pop;

    // Observation log.
    int   ncyc = 0;
    int   add_seen = 0;
    int   add_t[$];
    int   we_t[$];
    logic [7:0] add_a[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: the FIFO is a queue, an entry may leave once every three edges.
    initial begin
        m_valid = 1'b0;
        e_cnt   = 0;
        forever begin
            @(posedge clk);
            e_cnt++;
            if (rst) begin
                mq.delete();
                m_hold = '0; m_add = 0; m_we = 0; m_full = 0;
                m_sticky = 0; m_lc = 0; m_errc = 0;
                last_pop = -100;
                m_valid  = 1'b1;
            end else if (m_valid) begin
                m_acc = bus.cmd_valid && (mq.size() < FD);
                m_pop = (mq.size() > 0) && !m_full && (e_cnt - last_pop >= 3);
                m_lcn = bus.clear_list ? 0 : ((m_we && m_lc < int'(LD)) ? m_lc + 1 : m_lc);
                m_we  = m_add;
                m_add = m_pop;
                if (m_pop) begin
                    m_hold   = mq.pop_front();
                    last_pop = e_cnt;
                end
                if (m_acc) begin
                    m_new.a = bus.cmd_addr;
                    m_new.w = bus.cmd_way;
                    m_new.d = bus.cmd_data;
                    mq.push_back(m_new);
                end
                m_lc   = m_lcn;
                m_full = (m_lc == int'(LD));
                if (bus.plc_error_found) begin
                    m_sticky = 1'b1;
                    if (m_errc < 255) m_errc++;
                end
            end
        end
    end

    // Compare process: every falling edge once the model has seen reset.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (m_valid) begin
                chk("cmd_ready",    64'(bus.cmd_ready),    64'(!rst && mq.size() < FD));
                chk("add_to_list",  64'(bus.add_to_list),  64'(m_add));
                chk("write_enable", 64'(bus.write_enable), 64'(m_we));
                chk("addr_out",     64'(bus.addr_out),     64'(m_hold.a));
                chk("way_out",      64'(bus.way_out),      64'(m_hold.w));
                chk("data",         bus.data,              m_hold.d);
                chk("list_full",    64'(bus.list_full),    64'(m_full));
                chk("loaded_count", 64'(bus.loaded_count), 64'(m_lc));
                chk("error_sticky", 64'(bus.error_sticky), 64'(m_sticky));
                chk("error_count",  64'(bus.error_count),  64'(m_errc));
            end
            if (bus.add_to_list === 1'b1) begin
                add_seen++;
                add_t.push_back(ncyc);
                add_a.push_back(bus.addr_out);
            end
            if (bus.write_enable === 1'b1) we_t.push_back(ncyc);
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.clear_list = 1'b0;
        bus.plc_error_found = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_loaded", 64'(bus.loaded_count), 64'd0);
        chk("rst_data", bus.data, 64'd0);
        chk("rst_ready_after", 64'(bus.cmd_ready), 64'd1);
    endtask

    // Holds the entry on the bus until it is taken; returns just after that edge.
    task automatic push(input logic [7:0] a, input logic [3:0] w, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_way   = w;
        bus.cmd_data  = d;
        for (int i = 0; i < 64; i++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout actual=not_accepted required=accepted addr=%0h", a);
        end
    endtask

    task automatic stop();
        @(negedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int base;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_way = '0;
        bus.cmd_data = '0;
        bus.clear_list = 1'b0;
        bus.plc_error_found = 1'b0;

        // Single entry with latency check.
        do_reset();
        push(8'hAB, 4'hC, 64'h1122334455667788);
        stop();
        chk("single_add_early", 64'(bus.add_to_list), 64'd0);
        @(negedge clk);
        chk("single_add", 64'(bus.add_to_list), 64'd1);
        chk("single_add_we", 64'(bus.write_enable), 64'd0);
        chk("single_addr_a", 64'(bus.addr_out), 64'hAB);
        @(negedge clk);
        chk("single_we", 64'(bus.write_enable), 64'd1);
        chk("single_we_add", 64'(bus.add_to_list), 64'd0);
        chk("single_addr", 64'(bus.addr_out), 64'hAB);
        chk("single_way", 64'(bus.way_out), 64'hC);
        chk("single_data", bus.data, 64'h1122334455667788);
        @(negedge clk);
        chk("single_loaded", 64'(bus.loaded_count), 64'd1);
        chk("single_we_done", 64'(bus.write_enable), 64'd0);

        // Back-to-back entries.
        do_reset();
        add_t.delete(); we_t.delete(); add_a.delete();
        push(8'hAB, 4'hC, 64'h1);
        push(8'hDE, 4'hF, 64'h2);
        stop();
        repeat (12) @(negedge clk);
        chk("b2b_adds", 64'(add_t.size()), 64'd2);
        chk("b2b_wes", 64'(we_t.size()), 64'd2);
        if (add_t.size() == 2 && we_t.size() == 2) begin
            chk("b2b_spacing", 64'(add_t[1] - add_t[0]), 64'd3);
            chk("b2b_we0_lag", 64'(we_t[0] - add_t[0]), 64'd1);
            chk("b2b_we1_lag", 64'(we_t[1] - add_t[1]), 64'd1);
            chk("b2b_first", 64'(add_a[0]), 64'hAB);
            chk("b2b_second", 64'(add_a[1]), 64'hDE);
        end
        chk("b2b_loaded", 64'(bus.loaded_count), 64'd2);

        // Backpressure against a full list, then resume after clear.
        do_reset();
        base = add_seen;
        for (int i = 0; i < 6; i++) begin
            push(8'h10 + 8'(i), 4'(i), 64'(i) * 64'h0101010101010101);
        end
        stop();
        repeat (15) @(negedge clk);
        chk("bp_written", 64'(add_seen - base), 64'd2);
        chk("bp_loaded", 64'(bus.loaded_count), 64'd2);
        chk("bp_full", 64'(bus.list_full), 64'd1);
        chk("bp_ready", 64'(bus.cmd_ready), 64'd0);
        #1 bus.clear_list = 1'b1;
        @(negedge clk); #1 bus.clear_list = 1'b0;
        repeat (15) @(negedge clk);
        chk("bp_resume_written", 64'(add_seen - base), 64'd4);
        chk("bp_resume_addr", 64'(bus.addr_out), 64'h13);
        chk("bp_resume_full", 64'(bus.list_full), 64'd1);
        chk("bp_resume_ready", 64'(bus.cmd_ready), 64'd1);

        // Reset during the announce cycle abandons the entry.
        do_reset();
        we_t.delete();
        push(8'h5A, 4'h3, 64'hCAFE);
        stop();
        @(negedge clk);
        chk("mid_add", 64'(bus.add_to_list), 64'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_we", 64'(bus.write_enable), 64'd0);
        chk("mid_addr", 64'(bus.addr_out), 64'd0);
        chk("mid_data", bus.data, 64'd0);
        chk("mid_loaded", 64'(bus.loaded_count), 64'd0);
        #1 rst = 1'b0;
        base = add_seen;
        repeat (8) @(negedge clk);
        chk("mid_no_write", 64'(we_t.size()), 64'd0);
        chk("mid_fifo_empty", 64'(add_seen - base), 64'd0);

        // Error counting and saturation.
        do_reset();
        #1 bus.plc_error_found = 1'b1;
        repeat (100) @(negedge clk);
        chk("err_count_100", 64'(bus.error_count), 64'd100);
        repeat (200) @(negedge clk);
        #1 bus.plc_error_found = 1'b0;
        @(negedge clk);
        chk("err_sticky", 64'(bus.error_sticky), 64'd1);
        chk("err_sat", 64'(bus.error_count), 64'd255);
        #1 bus.clear_list = 1'b1;
        @(negedge clk); #1 bus.clear_list = 1'b0;
        @(negedge clk);
        chk("err_sticky_clr", 64'(bus.error_sticky), 64'd1);
        chk("err_count_clr", 64'(bus.error_count), 64'd255);

        // clear_list coinciding with the write increment.
        do_reset();
        push(8'h77, 4'h7, 64'h77);
        stop();
        @(negedge clk);
        @(negedge clk);
        chk("coll_we", 64'(bus.write_enable), 64'd1);
        #1 bus.clear_list = 1'b1;
        @(negedge clk);
        chk("coll_loaded", 64'(bus.loaded_count), 64'd0);
        #1 bus.clear_list = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
